// File: rtl/s_memory_arbiter_if.sv
// Client-side request/grant bus and RAM-side access port of the S-memory arbiter.
// master = task FSMs plus the RAM, slave = the arbiter.
interface s_memory_arbiter_if #(
    parameter int NUM_CLIENTS = 3,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8
);
    logic [NUM_CLIENTS-1:0]            req;
    logic [NUM_CLIENTS-1:0]            lock;
    logic [NUM_CLIENTS-1:0]            wr_en;
    logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr;
    logic [NUM_CLIENTS*DATA_WIDTH-1:0] wdata;
    logic [NUM_CLIENTS-1:0]            gnt;
    logic [NUM_CLIENTS-1:0]            ack;
    logic [NUM_CLIENTS-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]             rdata;
    logic [ADDR_WIDTH-1:0]             mem_addr;
    logic [DATA_WIDTH-1:0]             mem_wdata;
    logic                              mem_wren;
    logic [DATA_WIDTH-1:0]             mem_rdata;

    modport master (
        output req, lock, wr_en, addr, wdata, mem_rdata,
        input  gnt, ack, rvalid, rdata, mem_addr, mem_wdata, mem_wren
    );

    modport slave (
        input  req, lock, wr_en, addr, wdata, mem_rdata,
        output gnt, ack, rvalid, rdata, mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/s_memory_arbiter.sv
// Arbitrated single-port S-memory access: registered one-hot grant (1 cycle from IDLE), combinational access path,
// read data tagged back RD_LATENCY cycles after ack; non-granted clients simply wait, a lock holds the grant.
module s_memory_arbiter #(
    parameter int NUM_CLIENTS    = 3,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int RD_LATENCY     = 1,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic               clk,
    input  logic               reset,
    s_memory_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t                 r_state, w_state_nxt;
    logic [NUM_CLIENTS-1:0] r_gnt, w_gnt_nxt;
    logic [PTR_W-1:0]       r_ptr, w_ptr_nxt;
    logic [PTR_W-1:0]       r_gidx, w_gidx_nxt;
    logic [PTR_W-1:0]       w_winner;
    logic [NUM_CLIENTS-1:0] w_reqs;
    logic [NUM_CLIENTS-1:0] w_ack;
    logic [NUM_CLIENTS-1:0] w_rd_accept;
    logic                   w_access;
    logic [NUM_CLIENTS-1:0] r_tag [RD_LATENCY];

    // Round-robin scans upward from the client after the last winner; fixed priority scans from 0.
    function automatic logic [PTR_W-1:0] f_pick(input logic [NUM_CLIENTS-1:0] reqs,
                                                input logic [PTR_W-1:0]       ptr);
        logic [PTR_W-1:0] win;
        logic [PTR_W-1:0] cand;
        logic             found;
        int               idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (FIXED_PRIORITY != 0) idx = k;
            else                     idx = (int'(ptr) + 1 + k) % NUM_CLIENTS;
            cand = PTR_W'(idx);
            if (!found && reqs[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign w_reqs   = bus.req | bus.lock;
    assign w_winner = f_pick(w_reqs, r_ptr);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_gidx_nxt  = r_gidx;
        case (r_state)
            IDLE: begin
                if (|w_reqs) begin
                    w_gnt_nxt           = '0;
                    w_gnt_nxt[w_winner] = 1'b1;
                    w_ptr_nxt           = w_winner;
                    w_gidx_nxt          = w_winner;
                    w_state_nxt         = GRANTED;
                end
            end
            GRANTED: begin
                if (!w_reqs[r_gidx]) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= PTR_W'(NUM_CLIENTS - 1);
            r_gidx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gidx  <= w_gidx_nxt;
        end
    end

    // Reset gates the access path so nothing reaches the RAM or the tag pipe while it is high.
    assign w_access = !reset && r_gnt[r_gidx] && bus.req[r_gidx];

    always_comb begin
        w_ack         = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wren  = 1'b0;
        if (w_access) begin
            w_ack[r_gidx] = 1'b1;
            bus.mem_addr  = bus.addr[r_gidx*ADDR_WIDTH +: ADDR_WIDTH];
            bus.mem_wdata = bus.wdata[r_gidx*DATA_WIDTH +: DATA_WIDTH];
            bus.mem_wren  = bus.wr_en[r_gidx];
        end
    end

    assign w_rd_accept = w_ack & ~bus.wr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= w_rd_accept;
            for (int i = 1; i < RD_LATENCY; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.ack    = w_ack;
    assign bus.rvalid = reset ? '0 : r_tag[RD_LATENCY-1];
    assign bus.rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_s_memory_arbiter.sv
// Scoreboarded bench: dut_a is round-robin with 1-cycle RAM, dut_b fixed priority with 2-cycle RAM.
module tb_s_memory_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    always @(posedge clk) cyc <= cyc + 1;

    s_memory_arbiter_if #(.NUM_CLIENTS(3), .ADDR_WIDTH(8), .DATA_WIDTH(8)) bus_a();
    s_memory_arbiter_if #(.NUM_CLIENTS(3), .ADDR_WIDTH(8), .DATA_WIDTH(8)) bus_b();

    s_memory_arbiter #(.NUM_CLIENTS(3), .ADDR_WIDTH(8), .DATA_WIDTH(8),
                       .RD_LATENCY(1), .FIXED_PRIORITY(0))
        dut_a (.clk(clk), .reset(rst_a), .bus(bus_a.slave));
    s_memory_arbiter #(.NUM_CLIENTS(3), .ADDR_WIDTH(8), .DATA_WIDTH(8),
                       .RD_LATENCY(2), .FIXED_PRIORITY(1))
        dut_b (.clk(clk), .reset(rst_b), .bus(bus_b.slave));

    // RAM models: contents preset to addr^0x5A while their arbiter is in reset
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] rd_a, rd_b1, rd_b2;
    always @(posedge clk) begin
        if (rst_a) for (int i = 0; i < 256; i++) mem_a[i] <= 8'(i) ^ 8'h5A;
        else if (bus_a.mem_wren) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
        rd_a <= mem_a[bus_a.mem_addr];
    end
    always @(posedge clk) begin
        if (rst_b) for (int i = 0; i < 256; i++) mem_b[i] <= 8'(i) ^ 8'h5A;
        else if (bus_b.mem_wren) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
        rd_b1 <= mem_b[bus_b.mem_addr];
        rd_b2 <= rd_b1;
    end
    assign bus_a.mem_rdata = rd_a;
    assign bus_b.mem_rdata = rd_b2;

    typedef struct {
        int         at;
        int         dut;
        logic [2:0] who;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;
    ev_t ack_q[$];
    ev_t rv_q[$];

    task automatic exp_ack(input int d, input int at, input logic [2:0] who, input logic wr,
                           input logic [7:0] a, input logic [7:0] dt);
        ev_t e;
        e.at = at; e.dut = d; e.who = who; e.wr = wr; e.addr = a; e.data = dt;
        ack_q.push_back(e);
    endtask

    task automatic exp_rv(input int d, input int at, input logic [2:0] who, input logic [7:0] dt);
        ev_t e;
        e.at = at; e.dut = d; e.who = who; e.wr = 1'b0; e.addr = 8'h00; e.data = dt;
        rv_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon_ack(input int d, input logic [2:0] ack, input logic wr,
                           input logic [7:0] a, input logic [7:0] dt);
        ev_t e;
        n_vec++;
        if (ack_q.size() == 0) begin
            n_err++;
            $display("FAIL ack_unexpected: dut %0d ack %b at cycle %0d, expected no ack", d, ack, cyc);
        end else begin
            e = ack_q.pop_front();
            if (e.dut != d || e.at != cyc || e.who !== ack || e.wr !== wr ||
                e.addr !== a || e.data !== dt) begin
                n_err++;
                $display("FAIL ack_event: got dut %0d cyc %0d ack %b wr %b addr %h wdata %h, expected dut %0d cyc %0d ack %b wr %b addr %h wdata %h",
                         d, cyc, ack, wr, a, dt, e.dut, e.at, e.who, e.wr, e.addr, e.data);
            end
        end
    endtask

    task automatic mon_rv(input int d, input logic [2:0] rv, input logic [7:0] dt);
        ev_t e;
        n_vec++;
        if (rv_q.size() == 0) begin
            n_err++;
            $display("FAIL rvalid_unexpected: dut %0d rvalid %b at cycle %0d, expected none", d, rv, cyc);
        end else begin
            e = rv_q.pop_front();
            if (e.dut != d || e.at != cyc || e.who !== rv || e.data !== dt) begin
                n_err++;
                $display("FAIL rvalid_event: got dut %0d cyc %0d rvalid %b rdata %h, expected dut %0d cyc %0d rvalid %b rdata %h",
                         d, cyc, rv, dt, e.dut, e.at, e.who, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus_a.ack    !== 3'b000) mon_ack(0, bus_a.ack, bus_a.mem_wren, bus_a.mem_addr, bus_a.mem_wdata);
        if (bus_b.ack    !== 3'b000) mon_ack(1, bus_b.ack, bus_b.mem_wren, bus_b.mem_addr, bus_b.mem_wdata);
        if (bus_a.rvalid !== 3'b000) mon_rv(0, bus_a.rvalid, bus_a.rdata);
        if (bus_b.rvalid !== 3'b000) mon_rv(1, bus_b.rvalid, bus_b.rdata);
    end

    // One row = inputs for one cycle plus the grant expected in that cycle.
    task automatic drv_a(input logic rst, input logic [2:0] rq, input logic [2:0] lk,
                         input logic [2:0] wr, input logic [23:0] ad, input logic [23:0] dt,
                         input logic [2:0] eg, input bit cg);
        @(posedge clk); #1;
        rst_a = rst; bus_a.req = rq; bus_a.lock = lk; bus_a.wr_en = wr;
        bus_a.addr = ad; bus_a.wdata = dt;
        #1;
        if (cg) chk("gnt_a", 32'(bus_a.gnt), 32'(eg));
    endtask

    task automatic drv_b(input logic rst, input logic [2:0] rq, input logic [2:0] eg);
        @(posedge clk); #1;
        rst_b = rst; bus_b.req = rq;
        #1;
        chk("gnt_b", 32'(bus_b.gnt), 32'(eg));
    endtask

    localparam logic [23:0] AD0 = {8'h20, 8'h10, 8'h10};
    localparam logic [23:0] DT0 = {8'h55, 8'h00, 8'hAA};

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.req = '0; bus_a.lock = '0; bus_a.wr_en = '0; bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.req = '0; bus_b.lock = '0; bus_b.wr_en = '0;
        bus_b.addr = {8'h06, 8'h00, 8'h05}; bus_b.wdata = '0;

        // reset with every client requesting
        for (int r = 0; r < 2; r++) begin
            drv_a(1, 3'b111, 3'b000, 3'b101, AD0, DT0, 3'b000, 1);
            chk("rst_ack_a",    32'(bus_a.ack),      32'h0);
            chk("rst_rvalid_a", 32'(bus_a.rvalid),   32'h0);
            chk("rst_wren_a",   32'(bus_a.mem_wren), 32'h0);
        end
        // round-robin 0,1,2; client 0 writes 0x10<-AA, client 1 reads it back, client 2 writes 0x20<-55
        drv_a(0, 3'b111, 3'b000, 3'b101, AD0, DT0, 3'b000, 1);
        drv_a(0, 3'b111, 3'b000, 3'b101, AD0, DT0, 3'b001, 1); exp_ack(0, cyc, 3'b001, 1, 8'h10, 8'hAA);
        drv_a(0, 3'b110, 3'b000, 3'b101, AD0, DT0, 3'b001, 1);
        drv_a(0, 3'b110, 3'b000, 3'b101, AD0, DT0, 3'b000, 1);
        drv_a(0, 3'b110, 3'b000, 3'b101, AD0, DT0, 3'b010, 1); exp_ack(0, cyc, 3'b010, 0, 8'h10, 8'h00);
                                                               exp_rv(0, cyc + 1, 3'b010, 8'hAA);
        drv_a(0, 3'b100, 3'b000, 3'b101, AD0, DT0, 3'b010, 1);
        drv_a(0, 3'b100, 3'b000, 3'b101, AD0, DT0, 3'b000, 1);
        drv_a(0, 3'b100, 3'b000, 3'b101, AD0, DT0, 3'b100, 1); exp_ack(0, cyc, 3'b100, 1, 8'h20, 8'h55);
        drv_a(0, 3'b000, 3'b000, 3'b101, AD0, DT0, 3'b100, 1);
        drv_a(0, 3'b000, 3'b000, 3'b101, AD0, DT0, 3'b000, 1);

        // client 1 locked sequence while client 2 keeps requesting a write to 0xEE
        drv_a(0, 3'b110, 3'b010, 3'b100, {8'hEE, 8'h10, 8'h00}, {8'hEE, 8'h00, 8'h00}, 3'b000, 1);
        drv_a(0, 3'b110, 3'b010, 3'b100, {8'hEE, 8'h10, 8'h00}, {8'hEE, 8'h00, 8'h00}, 3'b010, 1);
        exp_ack(0, cyc, 3'b010, 0, 8'h10, 8'h00); exp_rv(0, cyc + 1, 3'b010, 8'hAA);
        drv_a(0, 3'b100, 3'b010, 3'b100, {8'hEE, 8'h10, 8'h00}, {8'hEE, 8'h00, 8'h00}, 3'b010, 1);
        chk("gap_wren", 32'(bus_a.mem_wren), 32'h0);
        chk("gap_addr", 32'(bus_a.mem_addr), 32'h0);
        chk("gap_ack",  32'(bus_a.ack),      32'h0);
        drv_a(0, 3'b110, 3'b010, 3'b100, {8'hEE, 8'h20, 8'h00}, {8'hEE, 8'h00, 8'h00}, 3'b010, 1);
        exp_ack(0, cyc, 3'b010, 0, 8'h20, 8'h00); exp_rv(0, cyc + 1, 3'b010, 8'h55);
        drv_a(0, 3'b110, 3'b010, 3'b100, {8'hEE, 8'h10, 8'h00}, {8'hEE, 8'h00, 8'h00}, 3'b010, 1);
        exp_ack(0, cyc, 3'b010, 0, 8'h10, 8'h00); exp_rv(0, cyc + 1, 3'b010, 8'hAA);
        drv_a(0, 3'b110, 3'b010, 3'b110, {8'hEE, 8'h30, 8'h00}, {8'hEE, 8'h77, 8'h00}, 3'b010, 1);
        exp_ack(0, cyc, 3'b010, 1, 8'h30, 8'h77);
        drv_a(0, 3'b110, 3'b010, 3'b100, {8'hEE, 8'h30, 8'h00}, {8'hEE, 8'h00, 8'h00}, 3'b010, 1);
        exp_ack(0, cyc, 3'b010, 0, 8'h30, 8'h00); exp_rv(0, cyc + 1, 3'b010, 8'h77);
        drv_a(0, 3'b110, 3'b010, 3'b110, {8'hEE, 8'h10, 8'h00}, {8'hEE, 8'h11, 8'h00}, 3'b010, 1);
        exp_ack(0, cyc, 3'b010, 1, 8'h10, 8'h11);
        drv_a(0, 3'b100, 3'b000, 3'b100, {8'hEE, 8'h10, 8'h00}, {8'hEE, 8'h11, 8'h00}, 3'b010, 1);
        drv_a(0, 3'b100, 3'b000, 3'b100, {8'hEE, 8'h10, 8'h00}, {8'hEE, 8'h11, 8'h00}, 3'b000, 1);
        drv_a(0, 3'b100, 3'b000, 3'b000, {8'h10, 8'h10, 8'h00}, 24'h0, 3'b100, 1);
        exp_ack(0, cyc, 3'b100, 0, 8'h10, 8'h00); exp_rv(0, cyc + 1, 3'b100, 8'h11);
        drv_a(0, 3'b000, 3'b000, 3'b000, {8'h10, 8'h10, 8'h00}, 24'h0, 3'b100, 1);
        drv_a(0, 3'b000, 3'b000, 3'b000, {8'h10, 8'h10, 8'h00}, 24'h0, 3'b000, 1);

        // reset lands in the cycle client 2's read would be accepted
        drv_a(0, 3'b100, 3'b000, 3'b000, {8'h20, 8'h00, 8'h00}, 24'h0, 3'b000, 1);
        drv_a(1, 3'b100, 3'b000, 3'b000, {8'h20, 8'h00, 8'h00}, 24'h0, 3'b000, 0);
        chk("rst_mid_ack",  32'(bus_a.ack),      32'h0);
        chk("rst_mid_addr", 32'(bus_a.mem_addr), 32'h0);
        for (int r = 0; r < 2; r++) begin
            drv_a(0, 3'b000, 3'b000, 3'b000, 24'h0, 24'h0, 3'b000, 1);
            chk("rst_mid_rvalid", 32'(bus_a.rvalid), 32'h0);
        end

        // fixed priority, 2-cycle RAM: client 0 keeps coming back and starves client 2
        for (int r = 0; r < 2; r++) begin
            drv_b(1, 3'b101, 3'b000);
            chk("rst_ack_b",    32'(bus_b.ack),    32'h0);
            chk("rst_rvalid_b", 32'(bus_b.rvalid), 32'h0);
        end
        drv_b(0, 3'b101, 3'b000);
        for (int r = 0; r < 3; r++) begin
            drv_b(0, 3'b101, 3'b001);
            exp_ack(1, cyc, 3'b001, 0, 8'h05, 8'h00); exp_rv(1, cyc + 2, 3'b001, 8'h5F);
            drv_b(0, 3'b100, 3'b001);
            drv_b(0, (r < 2) ? 3'b101 : 3'b100, 3'b000);
        end
        drv_b(0, 3'b100, 3'b100);
        exp_ack(1, cyc, 3'b100, 0, 8'h06, 8'h00); exp_rv(1, cyc + 2, 3'b100, 8'h5C);
        drv_b(0, 3'b000, 3'b100);
        drv_b(0, 3'b000, 3'b000);
        drv_b(0, 3'b000, 3'b000);

        @(posedge clk); #2;
        chk("ack_q_drained", 32'(ack_q.size()), 32'h0);
        chk("rv_q_drained",  32'(rv_q.size()),  32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
